// File: rtl/adc_ramp_train_ctrl_pkg.sv
// adc_train_pkg: shared types and constants for the ADC ramp training slice.
//   train_state_e : sequencer states
//   ITER_CNT_W    : width of the shared settle/check wait counter
//   PASS_CNT_W    : width of the per-channel consecutive-pass counter (PASS_COUNT <= 15)
//   slip_w()      : bitslip position width for a given PARALLEL_PATH_NUM
package adc_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_ON,
        ST_SETTLE,
        ST_DETECT,
        ST_WAIT,
        ST_EVAL,
        ST_CFG_OFF,
        ST_DONE
    } train_state_e;

    localparam int ITER_CNT_W = 16;
    localparam int PASS_CNT_W = 4;
    localparam int NUM_CH     = 4;

    // H and L halves of every parallel path are separate slip positions.
    function automatic int slip_w(input int parallel_path_num);
        return $clog2(2 * parallel_path_num);
    endfunction

endpackage

// File: rtl/adc_ramp_train_ctrl_if.sv
// adc_ramp_train_ctrl_if: start/status, config handshake, ramp checker and
// deserializer bitslip signals of the training sequencer.
//   master : sequencer view (drives detect_in, bitslip, cfg_*, status)
//   slave  : environment view (drives start, adc_is_ramp, cfg_ack)
interface adc_ramp_train_ctrl_if #(
    parameter int PARALLEL_PATH_NUM = 4
);
    import adc_train_pkg::*;

    localparam int SW = slip_w(PARALLEL_PATH_NUM);

    logic                 start;
    logic [NUM_CH-1:0]    adc_is_ramp;
    logic                 cfg_ack;
    logic                 detect_in;
    logic [NUM_CH-1:0]    bitslip;
    logic                 cfg_req;
    logic                 cfg_test_mode;
    logic                 busy;
    logic                 done;
    logic [NUM_CH-1:0]    locked;
    logic [NUM_CH-1:0]    fail;
    logic [NUM_CH*SW-1:0] slip_pos;

    modport master (
        input  start, adc_is_ramp, cfg_ack,
        output detect_in, bitslip, cfg_req, cfg_test_mode,
               busy, done, locked, fail, slip_pos
    );

    modport slave (
        output start, adc_is_ramp, cfg_ack,
        input  detect_in, bitslip, cfg_req, cfg_test_mode,
               busy, done, locked, fail, slip_pos
    );

endinterface

// File: rtl/adc_ramp_train_ctrl_chan_tracker.sv
// adc_train_chan_tracker: per-channel alignment state.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : clear all results at training start
//   eval         : one-cycle strobe in EVAL; ramp is only looked at here
//   ramp         : ramp-good flag for this channel
//   slip_req     : one-cycle bitslip pulse, the cycle after a failing EVAL
//   locked, fail : final per-channel result, frozen once either is set
//   settled_next : locked|fail as they will be after this cycle
//   slip_pos     : current bitslip count
module adc_train_chan_tracker
    import adc_train_pkg::*;
#(
    parameter int NPOS       = 8,
    parameter int PASS_COUNT = 4,
    parameter int SW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          eval,
    input  logic          ramp,
    output logic          slip_req,
    output logic          locked,
    output logic          fail,
    output logic          settled_next,
    output logic [SW-1:0] slip_pos
);

    localparam logic [SW-1:0]         LAST_POS = SW'(NPOS - 1);
    localparam logic [PASS_CNT_W-1:0] PASS_TGT = PASS_CNT_W'(PASS_COUNT);

    logic [PASS_CNT_W-1:0] pass_cnt, pass_cnt_d;
    logic [SW-1:0]         slip_pos_d;
    logic                  locked_d, fail_d, slip_d;

    always_comb begin
        pass_cnt_d = pass_cnt;
        slip_pos_d = slip_pos;
        locked_d   = locked;
        fail_d     = fail;
        slip_d     = 1'b0;
        if (clr) begin
            pass_cnt_d = '0;
            slip_pos_d = '0;
            locked_d   = 1'b0;
            fail_d     = 1'b0;
        end else if (eval && !locked && !fail) begin
            if (ramp) begin
                pass_cnt_d = pass_cnt + 1'b1;
                if (pass_cnt_d == PASS_TGT) locked_d = 1'b1;
            end else if (slip_pos != LAST_POS) begin
                // Any failure restarts the consecutive-pass run at the new slip.
                pass_cnt_d = '0;
                slip_pos_d = slip_pos + 1'b1;
                slip_d     = 1'b1;
            end else begin
                fail_d = 1'b1;
            end
        end
    end

    assign settled_next = locked_d | fail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            slip_pos <= '0;
            locked   <= 1'b0;
            fail     <= 1'b0;
            slip_req <= 1'b0;
        end else begin
            pass_cnt <= pass_cnt_d;
            slip_pos <= slip_pos_d;
            locked   <= locked_d;
            fail     <= fail_d;
            slip_req <= slip_d;
        end
    end

endmodule

// File: rtl/adc_ramp_train_ctrl.sv
// adc_ramp_train_ctrl: ramp-pattern word alignment sequencer for four ADC
// channels. Puts the ADC into ramp test mode, runs detect/check iterations,
// bitslips each channel until it locks or runs out of positions, then restores
// normal mode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : adc_ramp_train_ctrl_if.master (start/status, cfg handshake,
//              ramp checker and bitslip signals)
module adc_ramp_train_ctrl
    import adc_train_pkg::*;
#(
    parameter int PARALLEL_PATH_NUM = 4,
    parameter int SETTLE_CYCLES     = 16,
    parameter int CHECK_WAIT        = 64,
    parameter int PASS_COUNT        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    adc_ramp_train_ctrl_if.master  bus
);

    localparam int NPOS = 2 * PARALLEL_PATH_NUM;
    localparam int SW   = slip_w(PARALLEL_PATH_NUM);

    localparam logic [ITER_CNT_W-1:0] SETTLE_LAST = ITER_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ITER_CNT_W-1:0] CHECK_LAST  = ITER_CNT_W'(CHECK_WAIT - 1);

    train_state_e state, state_nxt;
    logic [ITER_CNT_W-1:0] wait_cnt;
    logic start_pend;
    logic train_go;
    logic eval;
    logic done_q;

    logic [NUM_CH-1:0]         slip_v, locked_v, fail_v, settled_v;
    logic [NUM_CH-1:0][SW-1:0] slip_pos_v;

    // A start landing in the DONE cycle is remembered and taken in IDLE.
    assign train_go = (state == ST_IDLE) && (bus.start || start_pend);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (train_go)                state_nxt = ST_CFG_ON;
            ST_CFG_ON:  if (bus.cfg_ack)             state_nxt = ST_SETTLE;
            ST_SETTLE:  if (wait_cnt == SETTLE_LAST) state_nxt = ST_DETECT;
            ST_DETECT:                               state_nxt = ST_WAIT;
            ST_WAIT:    if (wait_cnt == CHECK_LAST)  state_nxt = ST_EVAL;
            ST_EVAL:    state_nxt = (&settled_v) ? ST_CFG_OFF : ST_SETTLE;
            ST_CFG_OFF: if (bus.cfg_ack)             state_nxt = ST_DONE;
            ST_DONE:                                 state_nxt = ST_IDLE;
            default:                                 state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.cfg_req       = 1'b0;
        bus.cfg_test_mode = 1'b0;
        bus.detect_in     = 1'b0;
        bus.busy          = 1'b1;
        eval              = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: bus.busy = 1'b0;
            ST_CFG_ON: begin
                bus.cfg_req       = 1'b1;
                bus.cfg_test_mode = 1'b1;
            end
            ST_CFG_OFF: bus.cfg_req   = 1'b1;
            ST_DETECT:  bus.detect_in = 1'b1;
            ST_EVAL:    eval          = 1'b1;
            default: ;
        endcase
    end

    // One counter serves both SETTLE and WAIT; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || state != state_nxt) wait_cnt <= '0;
        else if (state == ST_SETTLE || state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_pend <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (state == ST_DONE && bus.start) start_pend <= 1'b1;
            else if (state == ST_IDLE)         start_pend <= 1'b0;
            if (state == ST_CFG_OFF && bus.cfg_ack) done_q <= 1'b1;
            else if (train_go)                      done_q <= 1'b0;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        adc_train_chan_tracker #(
            .NPOS       (NPOS),
            .PASS_COUNT (PASS_COUNT),
            .SW         (SW)
        ) u_trk (
            .clk          (clk),
            .rst          (rst),
            .clr          (train_go),
            .eval         (eval),
            .ramp         (bus.adc_is_ramp[ch]),
            .slip_req     (slip_v[ch]),
            .locked       (locked_v[ch]),
            .fail         (fail_v[ch]),
            .settled_next (settled_v[ch]),
            .slip_pos     (slip_pos_v[ch])
        );
    end

    assign bus.done     = done_q;
    assign bus.bitslip  = slip_v;
    assign bus.locked   = locked_v;
    assign bus.fail     = fail_v;
    assign bus.slip_pos = slip_pos_v;

endmodule

// File: tb/tb_adc_ramp_train_ctrl.sv
// Directed bench for adc_ramp_train_ctrl: SETTLE_CYCLES=2, CHECK_WAIT=4,
// PASS_COUNT=2, four parallel paths (8 slip positions, 8-cycle iterations).
// A small ramp-checker model answers from the bitslip/detect pulses it has seen.
module tb_adc_ramp_train_ctrl;
    import adc_train_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_ramp_train_ctrl_if #(.PARALLEL_PATH_NUM(4)) bus ();

    adc_ramp_train_ctrl #(
        .PARALLEL_PATH_NUM (4),
        .SETTLE_CYCLES     (2),
        .CHECK_WAIT        (4),
        .PASS_COUNT        (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int mode   = 0;
    bit ack_en = 1'b1;
    int ack_cnt = 0;
    int det_cnt = 0;
    int slips[4] = '{default: 0};
    int on_acks = 0;
    int off_acks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Ramp checker model: mode 0 all good, 1 B good only at slip 3,
    // 2 D never good, 3 A bad only in iteration 2.
    always_comb begin
        bus.adc_is_ramp = 4'hF;
        case (mode)
            1: bus.adc_is_ramp[1] = (slips[1] == 3);
            2: bus.adc_is_ramp[3] = 1'b0;
            3: bus.adc_is_ramp[0] = (det_cnt != 2);
            default: ;
        endcase
    end

    // Pulse counters and config responder (ack 3 cycles into each request).
    always @(negedge clk) begin
        if (bus.detect_in === 1'b1) det_cnt++;
        for (int i = 0; i < 4; i++) if (bus.bitslip[i] === 1'b1) slips[i]++;
        if (!ack_en || bus.cfg_req !== 1'b1 || bus.cfg_ack === 1'b1) begin
            bus.cfg_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            ack_cnt++;
            if (ack_cnt == 3) begin
                bus.cfg_ack = 1'b1;
                if (bus.cfg_test_mode) on_acks++;
                else                   off_acks++;
            end
        end
    end

    function automatic logic [31:0] outs();
        return {3'b0, bus.detect_in, bus.bitslip, bus.cfg_req, bus.cfg_test_mode,
                bus.busy, bus.done, bus.locked, bus.fail, bus.slip_pos};
    endfunction

    function automatic logic [31:0] slip_pk();
        return 32'(slips[0]) | (32'(slips[1]) << 8) | (32'(slips[2]) << 16) | (32'(slips[3]) << 24);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        det_cnt = 0;
        for (int i = 0; i < 4; i++) slips[i] = 0;
        on_acks = 0;
        off_acks = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
    endtask

    task automatic wait_det(input int n);
        int k = 0;
        while (det_cnt < n && k < 200) begin
            tick();
            k++;
        end
        chk("det_reached", 32'(det_cnt >= n), 32'd1);
    endtask

    task automatic run_case(input string tag, input int m, input logic [3:0] e_lock,
                            input logic [3:0] e_fail, input logic [11:0] e_pos,
                            input int e_iters, input logic [31:0] e_slips, input bit poke);
        mode = m;
        clear_counts();
        pulse_start();
        if (poke) begin
            wait_det(2);
            pulse_start();
        end
        wait_done(tag, 400);
        chk({tag, "_locked"}, 32'(bus.locked), 32'(e_lock));
        chk({tag, "_fail"}, 32'(bus.fail), 32'(e_fail));
        chk({tag, "_slip_pos"}, 32'(bus.slip_pos), 32'(e_pos));
        chk({tag, "_iters"}, 32'(det_cnt), 32'(e_iters));
        chk({tag, "_bitslips"}, slip_pk(), e_slips);
        chk({tag, "_acks"}, 32'(on_acks * 16 + off_acks), 32'h11);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        tick(2);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        bus.start = 1'b0;
        tick(3);
        chk("reset_outs", outs(), 32'd0);
        chk("reset_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        run_case("all_pass", 0, 4'hF, 4'h0, 12'h000, 2, 32'h0, 1'b0);
        run_case("b_slip3", 1, 4'hF, 4'h0, 12'h018, 5, 32'h0000_0300, 1'b1);
        run_case("d_fail", 2, 4'h7, 4'h8, 12'hE00, 8, 32'h0700_0000, 1'b0);
        run_case("a_pfpp", 3, 4'hF, 4'h0, 12'h001, 4, 32'h0000_0001, 1'b0);

        // Abort in WAIT of iteration 2.
        mode = 1;
        clear_counts();
        pulse_start();
        wait_det(2);
        tick();
        chk("pre_rst_state", 32'(dut.state), 32'(ST_WAIT));
        rst = 1'b1;
        tick();
        chk("rst_outs", outs(), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(2);
        run_case("after_rst", 0, 4'hF, 4'h0, 12'h000, 2, 32'h0, 1'b0);

        // Config block slow to acknowledge.
        ack_en = 1'b0;
        mode = 0;
        clear_counts();
        pulse_start();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.cfg_req !== 1'b1 || bus.busy !== 1'b1 || bus.cfg_test_mode !== 1'b1) bad++;
        end
        chk("ackhold_bad_cycles", 32'(bad), 32'd0);
        chk("ackhold_no_detect", 32'(det_cnt), 32'd0);
        ack_en = 1'b1;
        wait_done("ackhold", 400);
        chk("ackhold_locked", 32'(bus.locked), 32'hF);

        // start in the DONE cycle is taken once the sequencer is back in IDLE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_done_clr", 32'(bus.done), 32'd0);
        wait_done("b2b", 400);
        chk("b2b_locked", 32'(bus.locked), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
